// File: rtl/lcd_pkg.sv
// Shared definitions for the KS0108-class panel refresh engine: FSM state codes,
// controller instruction bytes, refresh mode codes and a width helper.
package lcd_pkg;

    typedef logic [2:0] lcd_state_t;

    localparam lcd_state_t ST_IDLE     = 3'd0;
    localparam lcd_state_t ST_DISP_ON  = 3'd1;
    localparam lcd_state_t ST_START_LN = 3'd2;
    localparam lcd_state_t ST_SET_PAGE = 3'd3;
    localparam lcd_state_t ST_SET_COL  = 3'd4;
    localparam lcd_state_t ST_WRITE    = 3'd5;
    localparam lcd_state_t ST_DONE     = 3'd6;

    localparam logic [7:0] INS_DISP_ON  = 8'h3F;
    localparam logic [7:0] INS_DISP_OFF = 8'h3E;
    localparam logic [7:0] INS_SET_Y    = 8'h40;
    localparam logic [7:0] INS_SET_X    = 8'hB8;
    localparam logic [7:0] INS_START    = 8'hC0;

    typedef logic [1:0] lcd_mode_t;

    localparam lcd_mode_t MODE_FRAME     = 2'b00;
    localparam lcd_mode_t MODE_FILL      = 2'b01;
    localparam lcd_mode_t MODE_PAGE      = 2'b10;
    localparam lcd_mode_t MODE_FRAME_ALT = 2'b11;

    // Counter width for n states; a single state still needs one bit of storage.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_en_divider.sv
// LCD enable strobe generator: ticks every EN_HALF clocks while run is high and
// toggles en on each tick; dropping run clears both the count and the strobe.
module lcd_en_divider
    import lcd_pkg::*;
#(
    parameter int EN_HALF = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic tick,
    output logic en
);

    localparam int DW = width_of(EN_HALF);
    localparam logic [DW-1:0] CNT_LAST = DW'(EN_HALF - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;

    assign tick = run && (cnt_q == CNT_LAST);
    assign en   = en_q;

    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        if (!run) begin
            cnt_d = '0;
            en_d  = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            en_d  = ~en_q;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/lcd_panel_refresh.sv
// Parametrised refresh engine for KS0108-class graphic LCDs: walks chips, pages and
// columns, streaming frame-buffer bytes (or a fill byte) to the panel with a busy/done handshake.
module lcd_panel_refresh
    import lcd_pkg::*;
#(
    parameter int NUM_CHIPS  = 2,
    parameter int PAGES      = 8,
    parameter int COLS       = 64,
    parameter int EN_HALF    = 2,
    parameter int START_LINE = 0,
    localparam int CW = width_of(NUM_CHIPS),
    localparam int PW = width_of(PAGES),
    localparam int YW = width_of(COLS),
    localparam int AW = CW + PW + YW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [7:0]           fill_i,
    input  logic [PW-1:0]        page_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AW-1:0]        addr_o,
    input  logic [7:0]           data_i,
    output logic [7:0]           db_o,
    output logic                 dori_o,
    output logic [NUM_CHIPS-1:0] cs_o,
    output logic                 en_o,
    output logic                 rw_o,
    output logic                 rst_o
);

    localparam logic [YW-1:0]        COL_LAST  = YW'(COLS - 1);
    localparam logic [PW-1:0]        PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0]        CHIP_LAST = CW'(NUM_CHIPS - 1);
    localparam logic [NUM_CHIPS-1:0] CS_ALL    = {NUM_CHIPS{1'b1}};
    localparam logic [7:0]           START_INS = INS_START | 8'(START_LINE % 64);

    lcd_state_t           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_prev_q, start_prev_d;
    lcd_mode_t            mode_q, mode_d;
    logic [7:0]           fill_q, fill_d;
    logic [PW-1:0]        page_sel_q, page_sel_d;
    logic [CW-1:0]        chip_q, chip_d;
    logic [PW-1:0]        page_q, page_d;
    logic [YW-1:0]        col_q, col_d;
    logic [7:0]           ins_q, ins_d;
    logic                 dori_q, dori_d;
    logic [NUM_CHIPS-1:0] cs_q, cs_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 rst_q, rst_d;

    logic                 tick;
    logic                 en;
    logic                 rise;
    logic                 start_edge;
    logic                 single;
    logic [NUM_CHIPS-1:0] chip_sel;

    lcd_en_divider #(
        .EN_HALF (EN_HALF)
    ) u_en_divider (
        .clk  (clk),
        .rstn (rstn),
        .run  (busy_q),
        .tick (tick),
        .en   (en)
    );

    // Each transaction is loaded on the tick that raises en and held until the next one.
    assign rise       = tick && !en;
    assign start_edge = start_i && !start_prev_q;
    assign single     = (mode_q == MODE_PAGE);
    assign chip_sel   = NUM_CHIPS'(1) << chip_q;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        start_prev_d = start_i;
        mode_d       = mode_q;
        fill_d       = fill_q;
        page_sel_d   = page_sel_q;
        chip_d       = chip_q;
        page_d       = page_q;
        col_d        = col_q;
        ins_d        = ins_q;
        dori_d       = dori_q;
        cs_d         = cs_q;
        addr_d       = addr_q;
        rst_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The clock carrying done_o still counts as busy for new requests.
                if (start_edge && !done_q) begin
                    mode_d     = mode_i;
                    fill_d     = fill_i;
                    page_sel_d = page_i;
                    chip_d     = '0;
                    page_d     = (mode_i == MODE_PAGE) ? page_i : '0;
                    col_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_DISP_ON;
                end
            end
            ST_DISP_ON: begin
                if (rise) begin
                    ins_d   = INS_DISP_ON;
                    dori_d  = 1'b0;
                    cs_d    = CS_ALL;
                    state_d = ST_START_LN;
                end
            end
            ST_START_LN: begin
                if (rise) begin
                    ins_d   = START_INS;
                    dori_d  = 1'b0;
                    cs_d    = CS_ALL;
                    state_d = ST_SET_PAGE;
                end
            end
            ST_SET_PAGE: begin
                if (rise) begin
                    ins_d   = INS_SET_X | 8'(page_q);
                    dori_d  = 1'b0;
                    cs_d    = chip_sel;
                    state_d = ST_SET_COL;
                end
            end
            ST_SET_COL: begin
                if (rise) begin
                    ins_d   = INS_SET_Y;
                    dori_d  = 1'b0;
                    cs_d    = chip_sel;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (rise) begin
                    dori_d = 1'b1;
                    cs_d   = chip_sel;
                    addr_d = {chip_q, page_q, col_q};
                    // The panel auto-increments Y, so only a row/chip wrap needs new addressing.
                    if (col_q != COL_LAST) begin
                        col_d = col_q + YW'(1);
                    end else begin
                        col_d   = '0;
                        state_d = ST_SET_PAGE;
                        if (!single && (page_q != PAGE_LAST)) begin
                            page_d = page_q + PW'(1);
                        end else begin
                            page_d = single ? page_sel_q : '0;
                            if (chip_q == CHIP_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                chip_d = chip_q + CW'(1);
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!en) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ins_d   = 8'h00;
                    dori_d  = 1'b0;
                    cs_d    = '0;
                    addr_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
            mode_q       <= MODE_FRAME;
            fill_q       <= 8'h00;
            page_sel_q   <= '0;
            chip_q       <= '0;
            page_q       <= '0;
            col_q        <= '0;
            ins_q        <= 8'h00;
            dori_q       <= 1'b0;
            cs_q         <= '0;
            addr_q       <= '0;
            rst_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_prev_q <= start_prev_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            page_sel_q   <= page_sel_d;
            chip_q       <= chip_d;
            page_q       <= page_d;
            col_q        <= col_d;
            ins_q        <= ins_d;
            dori_q       <= dori_d;
            cs_q         <= cs_d;
            addr_q       <= addr_d;
            rst_q        <= rst_d;
        end
    end

    assign db_o   = dori_q ? ((mode_q == MODE_FILL) ? fill_q : data_i) : ins_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign addr_o = addr_q;
    assign dori_o = dori_q;
    assign cs_o   = cs_q;
    assign en_o   = en;
    assign rw_o   = ~busy_q;
    assign rst_o  = rst_q;

endmodule
